pixel_frame_buffer: RTL and testbench

Ping-pong image buffer directly upstream of `cnn_top`. It accepts 28×28 8-bit pixel frames from a streaming source (UART/camera deframer) over a valid/ready handshake and stores them in one of two banks. It presents the filled bank to `cnn_top` through the same 1-cycle-latency `addra`/`douta` ROM port the CNN already uses. It issues a start pulse per frame and releases the bank when the CNN reports completion, so the next frame can load while the current one is classified.

---
 rtl/pixel_frame_buffer.sv | 163 ++++++++++++++++
 tb/tb_pixel_frame_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_buffer.sv
// rtl/pixel_frame_buffer.sv - ping-pong 28x28 pixel frame buffer feeding cnn_top
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   s_valid/s_data/s_last upstream pixel stream, s_ready back-pressure
//   addra -> douta        CNN read port, one cycle latency, zero when not busy
//   cnn_start             one-cycle pulse when a frame is handed to the CNN
//   cnn_done              CNN finished the frame it was given
//   frame_err             one-cycle pulse on a short or unterminated frame
//   rd_bank               bank currently owned by the reader
//   frames_done           count of frames released by cnn_done (wraps)
module pixel_frame_buffer #(
    parameter int PIX_W = 8,
    parameter int NPIX  = 784,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [PIX_W-1:0] s_data,
    input  logic             s_last,
    output logic             s_ready,
    input  logic [AW-1:0]    addra,
    output logic [PIX_W-1:0] douta,
    output logic             cnn_start,
    input  logic             cnn_done,
    output logic             frame_err,
    output logic             rd_bank,
    output logic [15:0]      frames_done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NPIX - 1);

    typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

    logic [PIX_W-1:0] mem0 [NPIX];
    logic [PIX_W-1:0] mem1 [NPIX];

    logic [1:0]    full;
    logic [1:0]    full_set;
    logic [1:0]    full_clr;
    logic          wr_bank;
    logic [AW-1:0] wr_cnt;

    rd_state_t state;
    rd_state_t state_next;

    logic accept;
    logic at_end;
    logic commit;
    logic short_frame;
    logic start_now;
    logic release_bank;

    // Ready depends only on registered flags so upstream never sees a
    // combinational path from its own valid.
    assign s_ready     = ~full[wr_bank];
    assign accept      = s_valid & s_ready;
    assign at_end      = (wr_cnt == LAST_IDX);
    assign commit      = accept & at_end;
    assign short_frame = accept & s_last & ~at_end;

    // Set and clear never hit the same bank: a bank being committed is
    // empty, a bank being released is full.
    assign full_set = commit       ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = release_bank ? (2'b01 << rd_bank) : 2'b00;

    // Pixel storage, not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (wr_bank) begin
                mem1[wr_cnt] <= s_data;
            end else begin
                mem0[wr_cnt] <= s_data;
            end
        end
    end

    // Write side: a long frame is still committed at the last slot; a
    // short frame is thrown away and the bank is refilled from slot 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank   <= 1'b0;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= (commit & ~s_last) | short_frame;
            if (commit) begin
                wr_bank <= ~wr_bank;
                wr_cnt  <= '0;
            end else if (short_frame) begin
                wr_cnt  <= '0;
            end else if (accept) begin
                wr_cnt  <= wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full <= 2'b00;
        end else begin
            full <= (full | full_set) & ~full_clr;
        end
    end

    // Read FSM: state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= R_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM: next state.
    always_comb begin
        state_next = state;
        case (state)
            R_IDLE: if (full[rd_bank]) state_next = R_BUSY;
            R_BUSY: if (cnn_done)      state_next = R_IDLE;
            default:                   state_next = R_IDLE;
        endcase
    end

    // Read FSM: outputs. cnn_done is only meaningful while busy.
    always_comb begin
        start_now    = 1'b0;
        release_bank = 1'b0;
        case (state)
            R_IDLE:  start_now    = full[rd_bank];
            R_BUSY:  release_bank = cnn_done;
            default: ;
        endcase
    end

    // Start is registered so it coincides with the first busy cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnn_start   <= 1'b0;
            rd_bank     <= 1'b0;
            frames_done <= '0;
        end else begin
            cnn_start <= start_now;
            if (release_bank) begin
                rd_bank     <= ~rd_bank;
                frames_done <= frames_done + 16'd1;
            end
        end
    end

    // Registered read port; out-of-range or idle reads return zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            douta <= '0;
        end else if (state == R_BUSY && addra <= LAST_IDX) begin
            douta <= rd_bank ? mem1[addra] : mem0[addra];
        end else begin
            douta <= '0;
        end
    end

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// tb/tb_pixel_frame_buffer.sv - randomized self-checking bench for pixel_frame_buffer
module tb_pixel_frame_buffer;

    localparam int NPIX = 784;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_last = 1'b0;
    logic [9:0] addra = 10'd0;
    logic       cnn_done = 1'b0;
    logic       s_ready;
    logic [7:0] douta;
    logic       cnn_start;
    logic       frame_err;
    logic       rd_bank;
    logic [15:0] frames_done;

    pixel_frame_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .addra       (addra),
        .douta       (douta),
        .cnn_start   (cnn_start),
        .cnn_done    (cnn_done),
        .frame_err   (frame_err),
        .rd_bank     (rd_bank),
        .frames_done (frames_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: committed frames form a FIFO of at most two;
    // the reader holds the oldest one from its start pulse until done.
    logic [7:0] mf [2][NPIX];
    int   head, held, held_pre, tail, cur_len;
    bit   busy, armed, frame_end;
    logic       e_ready, e_start, e_err, e_rdbank;
    logic [7:0] e_douta;
    logic [15:0] e_frames;

    initial begin
        armed = 0;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                head = 0; held = 0; cur_len = 0; busy = 0;
                e_ready = 1; e_start = 0; e_err = 0; e_rdbank = 0;
                e_douta = 0; e_frames = 0;
                frame_end = 1; armed = 1;
            end else begin
                held_pre = held;
                tail = (head + held) % 2;
                e_douta = (busy && int'(addra) < NPIX) ? mf[head][addra] : 8'd0;
                e_start = 0;
                if (!busy) begin
                    if (held > 0) begin
                        busy = 1;
                        e_start = 1;
                    end
                end else if (cnn_done) begin
                    busy = 0;
                    head = (head + 1) % 2;
                    held--;
                    e_frames = e_frames + 16'd1;
                    e_rdbank = ~e_rdbank;
                end
                e_err = 0;
                if (s_valid && held_pre < 2) begin
                    mf[tail][cur_len] = s_data;
                    if (cur_len == NPIX - 1) begin
                        held++;
                        e_err = !s_last;
                        cur_len = 0;
                        frame_end = 1;
                    end else if (s_last) begin
                        e_err = 1;
                        cur_len = 0;
                        frame_end = 1;
                    end else begin
                        cur_len++;
                    end
                end
                e_ready = (held < 2);
            end
        end
    end

    // Single compare process, every cycle once reset has been seen.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("s_ready",     32'(s_ready),     32'(e_ready));
                chk("cnn_start",   32'(cnn_start),   32'(e_start));
                chk("frame_err",   32'(frame_err),   32'(e_err));
                chk("rd_bank",     32'(rd_bank),     32'(e_rdbank));
                chk("frames_done", 32'(frames_done), 32'(e_frames));
                chk("douta",       32'(douta),       32'(e_douta));
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_frame(input int n, input int last_at, input int mult, input int done_at);
        for (int i = 0; i < n; i++) begin
            s_valid  = 1'b1;
            s_data   = 8'(i * mult);
            s_last   = (i == last_at);
            cnn_done = (i == done_at);
            step();
        end
        s_valid = 1'b0; s_last = 1'b0; cnn_done = 1'b0;
    endtask

    int plan_last;

    initial begin
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_douta", 32'(douta), 32'd0);
        chk("rst_start", 32'(cnn_start), 32'd0);
        chk("rst_frames", 32'(frames_done), 32'd0);
        rst_n = 1'b1;

        // Frame A into B0, pixel = addr mod 256.
        send_frame(NPIX, NPIX - 1, 1, -1);
        chk("start_e0", 32'(cnn_start), 32'd0);
        step();
        chk("start_e1", 32'(cnn_start), 32'd1);
        step();
        chk("start_e2", 32'(cnn_start), 32'd0);
        addra = 10'd0;   step(); chk("rd_0",   32'(douta), 32'h00);
        addra = 10'd100; step(); chk("rd_100", 32'(douta), 32'h64);
        addra = 10'd783; step(); chk("rd_783", 32'(douta), 32'h0F);
        addra = 10'd800; step(); chk("rd_800", 32'(douta), 32'h00);

        // Frame B fills B1: both full, writer stalls.
        send_frame(NPIX, NPIX - 1, 3, -1);
        chk("stall_ready", 32'(s_ready), 32'd0);
        repeat (3) step();
        chk("stall_hold", 32'(s_ready), 32'd0);
        cnn_done = 1'b1; step(); cnn_done = 1'b0;
        chk("rel_ready", 32'(s_ready), 32'd1);
        chk("rel_bank", 32'(rd_bank), 32'd1);
        chk("rel_frames", 32'(frames_done), 32'd1);
        addra = 10'd5; step();
        chk("start_b", 32'(cnn_start), 32'd1);
        step();
        chk("rd_b5", 32'(douta), 32'd15);

        // Commit into B0 on the same edge that B1 is released.
        send_frame(NPIX, NPIX - 1, 5, NPIX - 1);
        chk("same_bank", 32'(rd_bank), 32'd0);
        chk("same_frames", 32'(frames_done), 32'd2);
        chk("same_ready", 32'(s_ready), 32'd1);
        step();
        chk("same_start", 32'(cnn_start), 32'd1);

        // Short frame into B1.
        send_frame(501, 500, 1, -1);
        chk("short_err", 32'(frame_err), 32'd1);
        step();
        chk("short_err_off", 32'(frame_err), 32'd0);

        // Release B0, then a long frame into B1 plus one extra beat.
        cnn_done = 1'b1; step(); cnn_done = 1'b0;
        step();
        send_frame(NPIX, -1, 7, -1);
        chk("long_err", 32'(frame_err), 32'd1);
        s_valid = 1'b1; s_data = 8'hA5; step(); s_valid = 1'b0;
        chk("long_start", 32'(cnn_start), 32'd1);

        // Randomized traffic with one mid-run reset.
        frame_end = 1;
        plan_last = -1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (cyc == 5000) begin
                s_valid = 1'b0; cnn_done = 1'b0; rst_n = 1'b0;
                step();
                chk("mid_rst_bank", 32'(rd_bank), 32'd0);
                chk("mid_rst_frames", 32'(frames_done), 32'd0);
                chk("mid_rst_ready", 32'(s_ready), 32'd1);
                rst_n = 1'b1;
            end
            if (frame_end) begin
                frame_end = 0;
                case ($urandom_range(0, 7))
                    0:       plan_last = $urandom_range(0, NPIX - 2);
                    1:       plan_last = -1;
                    default: plan_last = NPIX - 1;
                endcase
            end
            s_valid  = ($urandom_range(0, 3) != 0);
            s_data   = 8'($urandom);
            s_last   = (cur_len == plan_last);
            addra    = 10'($urandom);
            cnn_done = ($urandom_range(0, 39) == 0);
            step();
        end
        s_valid = 1'b0; cnn_done = 1'b0;
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
